// File: rtl/chaser_pkg.sv
// Shared encodings and defaults for the LED chaser and its button debouncers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package chaser_pkg;

  // Direction encodings: LEFT moves the lit bit toward the MSB.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Mode encodings; bounce is only honoured when CHASER_BOUNCE_EN is defined.
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  // Default debounce window in clocks (1 ms at 50 MHz).
  localparam logic [15:0] DB_CYCLES_DEFAULT = 16'd50000;

  // True when exactly one bit of v is set (v is zero-extended by callers).
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability debouncer, press pulse.
// Latency: press pulses DB_CYCLES+1 clocks after the raw input settles low.
// Backpressure: none; the input is sampled every clock.
// Ports: clk, rst (async active-high), btn_n (raw active-low button),
//        press (one-cycle pulse on a debounced 1->0 transition).
module btn_debounce
  import chaser_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  logic        differ;
  logic        done;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    differ   = (sync2_q != stable_q);
    done     = differ && (cnt_q == (DB_CYCLES - 16'd1));
    cnt_d    = 16'd0;
    stable_d = stable_q;
    if (differ) begin
      cnt_d = done ? 16'd0 : (cnt_q + 16'd1);
    end
    if (done) begin
      stable_d = sync2_q;
    end
    // fill_q[1] marks the point where sync2_q carries the real pin value
    // rather than its reset value. A button already held at that point
    // must be seen released before any press counts.
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & sync2_q);
    // Pulse in the cycle the stable level is about to fall.
    press   = done & stable_q & armed_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= 16'd0;
      fill_q   <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      armed_q  <= armed_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// One-hot LED chaser stepped by a prescaler tick or a debounced step button.
// Latency: LEDS/dir update on the clock after an advance; press adds DB_CYCLES+1.
// Backpressure: none; every advance event is applied immediately.
// Ports: CLOCK_50, RESET (async active-high), step_n/dir_n (raw active-low
//        buttons), run, mode (0 rotate / 1 bounce), LEDS, dir, tick.
// Optional: define CHASER_BOUNCE_EN to honour mode=1 (bounce at the ends);
//           without it mode is ignored and the chaser always rotates.
module led_chaser
  import chaser_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int          DIV_BITS  = 21,
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             step_n,
  input  logic             dir_n,
  input  logic             run,
  input  logic             mode,
  output logic [WIDTH-1:0] LEDS,
  output logic             dir,
  output logic             tick
);

  logic [DIV_BITS-1:0] pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [WIDTH-1:0]    leds_q, leds_d;
  logic                dir_q, dir_d;
  logic                step_press;
  logic                dir_press;
  logic                advance;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .btn_n (step_n),
    .press (step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dir_db (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .btn_n (dir_n),
    .press (dir_press)
  );

`ifndef CHASER_BOUNCE_EN
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    pre_d = pre_q + DIV_BITS'(1);
    // Registered tick is high while pre_q holds the all-ones count.
    tick_d = &pre_d;
    advance = (run & tick_q) | step_press;
    // A coincident direction press is applied before the step.
    dir_d  = dir_q ^ dir_press;
    leds_d = leds_q;
    if (!is_onehot(32'(leds_q))) begin
      leds_d = WIDTH'(1);
    end else if (advance) begin
`ifdef CHASER_BOUNCE_EN
      if ((mode == MODE_BOUNCE) &&
          (((dir_d == DIR_LEFT) && leds_q[WIDTH-1]) ||
           ((dir_d == DIR_RIGHT) && leds_q[0]))) begin
        dir_d = ~dir_d;
      end
`endif
      if (dir_d == DIR_LEFT) begin
        leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
      end else begin
        leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      leds_q <= WIDTH'(1);
      dir_q  <= DIR_RIGHT;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      leds_q <= leds_d;
      dir_q  <= dir_d;
    end
  end

  assign LEDS = leds_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser (WIDTH=4, DIV_BITS=3, DB_CYCLES=4).
// Expected {dir,LEDS} pairs are queued when stimulus is applied and popped
// when the DUT output is sampled on the falling edge.
module tb_led_chaser;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       step_n;
  logic       dir_n;
  logic       run;
  logic       mode;
  logic [3:0] LEDS;
  logic       dir;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [4:0] sb_q[$];

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  led_chaser #(.WIDTH(4), .DIV_BITS(3), .DB_CYCLES(16'd4)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .step_n   (step_n),
    .dir_n    (dir_n),
    .run      (run),
    .mode     (mode),
    .LEDS     (LEDS),
    .dir      (dir),
    .tick     (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [4:0] e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(tag, {27'd0, dir, LEDS}, {27'd0, e});
    end
  endtask

  task automatic wait_tick(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_tick expected=tick_within_40", tag);
    end
  endtask

  task automatic press(input bit use_dir, input int hold);
    if (use_dir) dir_n = 1'b0; else step_n = 1'b0;
    repeat (hold) @(negedge CLOCK_50);
    dir_n  = 1'b1;
    step_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, toggles, lat, found;
    logic prev;
    logic [4:0] exp29[4];
    logic [4:0] exp33[3];
    exp29 = '{5'b0_1000, 5'b0_0100, 5'b0_0010, 5'b0_0001};
`ifdef CHASER_BOUNCE_EN
    exp33 = '{5'b1_0100, 5'b1_1000, 5'b0_0100};
`else
    exp33 = '{5'b1_0100, 5'b1_1000, 5'b1_0001};
`endif

    // Reset state
    RESET = 1'b1; step_n = 1'b1; dir_n = 1'b1; run = 1'b0; mode = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_leds", {28'd0, LEDS}, 32'd1);
    check("rst_dir", {31'd0, dir}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    RESET = 1'b0;
    run   = 1'b1;

    // Free-running rotate right, tick every 8 clocks
    wait_tick("tick_first", t0);
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(exp29[k]);
      @(negedge CLOCK_50);
      sb_check($sformatf("auto_step%0d", k));
      if (k < 3) begin
        wait_tick("tick_next", t1);
        check("tick_period", t1 - t0, 8);
        t0 = t1;
      end
    end
    run = 1'b0;

    // Clean dir press held 10 clocks
    toggles = 0; prev = dir;
    dir_n = 1'b0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (dir !== prev) toggles++;
      prev = dir;
    end
    dir_n = 1'b1;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (dir !== prev) toggles++;
      prev = dir;
    end
    check("dir_clean_toggles", toggles, 1);
    check("dir_clean_val", {31'd0, dir}, 32'd1);
    check("dir_press_no_step", {28'd0, LEDS}, 32'd1);
    wait_tick("tick_sync", t0);
    @(negedge CLOCK_50);
    run = 1'b1;
    wait_tick("tick_l1", t0);
    sb_q.push_back(5'b1_0010);
    @(negedge CLOCK_50);
    sb_check("left_step1");
    wait_tick("tick_l2", t0);
    sb_q.push_back(5'b1_0100);
    @(negedge CLOCK_50);
    sb_check("left_step2");
    run = 1'b0;

    // Bouncing dir press: 0-1-0-1 at 2-clock intervals, then held low
    toggles = 0; prev = dir;
    for (int b = 0; b < 4; b++) begin
      dir_n = (b % 2 == 1);
      repeat (2) begin
        @(negedge CLOCK_50);
        if (dir !== prev) toggles++;
        prev = dir;
      end
    end
    check("bounce_no_early_toggle", toggles, 0);
    dir_n = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLOCK_50);
      if (dir !== prev) begin
        lat = n;
        break;
      end
    end
    check("bounce_latency", lat, 6);
    prev = dir; toggles = 0;
    repeat (8) begin
      @(negedge CLOCK_50);
      if (dir !== prev) toggles++;
      prev = dir;
    end
    dir_n = 1'b1;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (dir !== prev) toggles++;
      prev = dir;
    end
    check("bounce_single_toggle", toggles, 0);
    check("bounce_dir_val", {31'd0, dir}, 32'd0);

    // Manual steps with run=0
    sb_q.push_back(5'b0_0010);
    press(1'b0, 10);
    sb_check("step1");
    sb_q.push_back(5'b0_0001);
    press(1'b0, 10);
    sb_check("step2");

    // Step press coinciding with a tick while run=1
    wait_tick("tick_coin", t0);
    repeat (3) @(negedge CLOCK_50);
    step_n = 1'b0;
    run    = 1'b1;
    sb_q.push_back(5'b0_1000);
    repeat (6) @(negedge CLOCK_50);
    run = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    step_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    sb_check("step_tick_coincident");

    // Mode test starting from 0010 with dir=1
    press(1'b1, 10);
    sb_q.push_back(5'b1_0001);
    press(1'b0, 10);
    sb_check("setup_step1");
    sb_q.push_back(5'b1_0010);
    press(1'b0, 10);
    sb_check("setup_step2");
    mode = 1'b1;
    wait_tick("tick_msync", t0);
    @(negedge CLOCK_50);
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick("tick_mode", t0);
      sb_q.push_back(exp33[k]);
      @(negedge CLOCK_50);
      sb_check($sformatf("mode_step%0d", k));
    end
    run  = 1'b0;
    mode = 1'b0;

    // Reset mid-sequence at LEDS=0100 with dir=1
`ifdef CHASER_BOUNCE_EN
    press(1'b1, 10);
`endif
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (LEDS === 4'b0100 && dir === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("reach_0100", found, 1);
    #1;
    RESET  = 1'b1;
    step_n = 1'b0;
    #1;
    check("async_rst_leds", {28'd0, LEDS}, 32'd1);
    check("async_rst_dir", {31'd0, dir}, 32'd0);
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    run = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    check("held_through_reset", {28'd0, LEDS}, 32'd1);
    step_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("release_after_reset", {28'd0, LEDS}, 32'd1);
    sb_q.push_back(5'b0_1000);
    press(1'b0, 10);
    sb_check("step_after_rearm");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of LEDs in the chaser; legal range 2..32.
REQ-002 SHALL have parameter DIV_BITS, default 21: prescaler width; auto-step period is 2^DIV_BITS clocks.
REQ-003 SHALL have parameter DB_CYCLES, default 16'd50000: debounce stability window, in clocks; legal range 1..65535.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port step_n, input, 1 bit: manual-step pushbutton, active-low, asynchronous to CLOCK_50.
REQ-007 SHALL have port dir_n, input, 1 bit: direction-toggle pushbutton, active-low, asynchronous.
REQ-008 SHALL have port run, input, 1 bit: when 1, the chaser steps on every prescaler tick.
REQ-009 SHALL have port mode, input, 1 bit: 0 = rotate, 1 = bounce; used only when CHASER_BOUNCE_EN is defined.
REQ-010 SHALL have port LEDS, output, WIDTH bits: the one-hot LED pattern.
REQ-011 SHALL have port dir, output, 1 bit: current direction; 1 = toward MSB, 0 = toward LSB.
REQ-012 SHALL have port tick, output, 1 bit: a one-cycle pulse each time the prescaler wraps.

Function
REQ-013 SHALL increment the prescaler counter every clock, wrap it from 2^DIV_BITS-1 to 0, and assert tick during the cycle in which the count equals 2^DIV_BITS-1.
REQ-014 SHALL pass each button through a 2-flop synchronizer, then through a debouncer that updates its stable level only after the synchronized input has differed from it for DB_CYCLES consecutive clocks; any bounce restarts the count.
REQ-015 SHALL generate a one-cycle press pulse on each 1->0 transition of a stable (debounced) level; holding a button yields exactly one pulse, and release yields none.
REQ-016 SHALL toggle dir on each dir_n press pulse.
REQ-017 SHALL raise an advance event when (run AND tick) OR step press pulse; coincident sources still produce one step only.
REQ-018 SHALL, when a dir press and an advance coincide, apply the toggle first; that step moves in the new direction.
REQ-019 SHALL, in rotate mode with dir=1, shift LEDS left with MSB wrapping to bit 0; with dir=0, shift right with bit 0 wrapping to MSB.
REQ-020 SHALL, in bounce mode, on an advance with the lit bit at the end of travel (MSB with dir=1, or bit 0 with dir=0), invert dir and move one position the opposite way; for WIDTH=4, 1000 with dir=1 -> 0100 with dir=0.
REQ-021 SHALL register LEDS, dir and tick outputs; LEDS changes in the clock following the advance event.
REQ-022 SHALL force LEDS to 1 on the next clock if LEDS is ever not one-hot (recovery).

Reset
REQ-023 SHALL, while RESET=1, immediately force LEDS=1, dir=0, tick=0, the prescaler to 0, debouncer counters to 0, and stable button levels to 1 (released).
REQ-024 SHALL NOT generate a press pulse on reset release while a button is already held, until that button is released and pressed again.
REQ-025 SHALL, if reset asserts mid-debounce or mid-step, discard any pending press and leave no partial shift.

Configuration
REQ-026 SHALL implement bounce mode (REQ-020) only when macro CHASER_BOUNCE_EN is defined; without it, mode is ignored and the block always rotates.

Structure
REQ-027 SHALL place the direction encodings (DIR_LEFT=1, DIR_RIGHT=0), mode encodings (MODE_ROTATE=0, MODE_BOUNCE=1) and the default DB_CYCLES in the shared package chaser_pkg.
REQ-028 SHALL implement synchronizer + debouncer + press-pulse logic as sub-module btn_debounce (parameter DB_CYCLES), instantiated once per button.

Verification (WIDTH=4, DIV_BITS=3, DB_CYCLES=4)
REQ-029 SHALL verify that with run=1 and buttons idle after reset, tick pulses every 8 clocks and LEDS goes 0001->1000->0100->0010->0001.
REQ-030 SHALL verify that a clean dir_n press held for 10 clocks toggles dir exactly once, and that the next ticks step 0001->0010->0100.
REQ-031 SHALL verify that dir_n bouncing 1-0-1-0 at 2-clock intervals and then held low produces exactly one toggle, DB_CYCLES+2 clocks after it settles.
REQ-032 SHALL verify that with run=0, each step_n press advances exactly one position, and that a step press coinciding with tick while run=1 advances only one position.
REQ-033 SHALL verify that with CHASER_BOUNCE_EN defined, mode=1 and dir=1, LEDS goes 0010->0100->1000->0100 with dir=0, and goes 0010->0100->1000->0001 when the macro is undefined.
REQ-034 SHALL verify that asserting RESET mid-sequence (LEDS=0100) gives LEDS=0001 and dir=0 with no clock edge, and that step_n held through reset release gives no step.
